alu_flag_unit: RTL and testbench

//  Pipelined, parametrised condition-flag generator for the ALU datapath.

---
 rtl/alu_flag_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_flag_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// -----------------------------------------------------------------------------
// alu_flag_unit
//
// Pipelined condition-flag generator that sits beside the ALU core. For every
// issued operation it takes the operands and the datapath result, then
// produces registered carry / zero / sign / overflow flags per SIMD lane. It
// also keeps sticky carry and overflow status that accumulates until cleared.
// out_valid lines up with the core's 2-cycle result register.
//
// Parameters
//   WIDTH     total operand/result width in bits
//   LANES     number of independent SIMD lanes (WIDTH must divide evenly)
//   STICKY_EN 1: sticky_c/sticky_o accumulate, 0: sticky outputs tied to 0
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operation present on the inputs this cycle
//   opsel      in   3      operation select (ADD/ADC/SUB/SBB/INC/DEC/NEG/CMP)
//   mode       in   1      0 = arithmetic, 1 = logic
//   cin        in   1      carry in, shared by every lane
//   a, b       in   WIDTH  operands; lane i = bits [i*LW +: LW]
//   result     in   WIDTH  datapath result for the same operation
//   sticky_clr in   1      clear the sticky flags
//   out_valid  out  1      flag outputs were updated this cycle
//   c_flag     out  LANES  carry per lane (1 = no borrow for subtract forms)
//   z_flag     out  LANES  zero per lane
//   s_flag     out  LANES  sign (lane MSB) per lane
//   o_flag     out  LANES  signed overflow per lane
//   sticky_c   out  LANES  OR of c_flag since the last clear
//   sticky_o   out  LANES  OR of o_flag since the last clear
// -----------------------------------------------------------------------------
module alu_flag_unit #(
    parameter int WIDTH     = 128,
    parameter int LANES     = 1,
    parameter bit STICKY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       opsel,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             sticky_clr,
    output logic             out_valid,
    output logic [LANES-1:0] c_flag,
    output logic [LANES-1:0] z_flag,
    output logic [LANES-1:0] s_flag,
    output logic [LANES-1:0] o_flag,
    output logic [LANES-1:0] sticky_c,
    output logic [LANES-1:0] sticky_o
);

    localparam int LW = WIDTH / LANES;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBB = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_NEG = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    // Per-lane effective operands and the extended sum
    logic [LANES-1:0][LW-1:0] w_a_eff;
    logic [LANES-1:0][LW-1:0] w_b_eff;
    logic [LANES-1:0]         w_c0;
    logic [LANES-1:0][LW:0]   w_sum;
    logic [LANES-1:0]         w_amsb;
    logic [LANES-1:0]         w_bmsb;

    // Stage-1 registers
    logic                     r_vld_p1;
    logic [LANES-1:0][LW:0]   r_sum_p1;
    logic [LANES-1:0]         r_amsb_p1;
    logic [LANES-1:0]         r_bmsb_p1;
    logic [WIDTH-1:0]         r_res_p1;
    logic                     r_logic_p1;
    logic                     r_cmp_p1;

    // Flags computed from stage-1 state
    logic [LANES-1:0]         w_c_new;
    logic [LANES-1:0]         w_z_new;
    logic [LANES-1:0]         w_s_new;
    logic [LANES-1:0]         w_o_new;

    // Stage-2 registers
    logic                     r_vld_p2;
    logic [LANES-1:0]         r_c_p2;
    logic [LANES-1:0]         r_z_p2;
    logic [LANES-1:0]         r_s_p2;
    logic [LANES-1:0]         r_o_p2;

    // Operand conditioning: each lane adds independently, with cin fanned
    // out to every lane, so no carry crosses a lane boundary.
    always_comb begin
        w_a_eff = '0;
        w_b_eff = '0;
        w_c0    = '0;
        w_sum   = '0;
        w_amsb  = '0;
        w_bmsb  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_a_eff[i] = a[i*LW +: LW];
            w_b_eff[i] = b[i*LW +: LW];
            w_c0[i]    = 1'b0;
            case (opsel)
                OP_ADD: begin
                    w_c0[i] = 1'b0;
                end
                OP_ADC: begin
                    w_c0[i] = cin;
                end
                OP_SUB: begin
                    w_b_eff[i] = ~b[i*LW +: LW];
                    w_c0[i]    = 1'b1;
                end
                OP_SBB: begin
                    w_b_eff[i] = ~b[i*LW +: LW];
                    w_c0[i]    = cin;
                end
                OP_INC: begin
                    w_b_eff[i] = '0;
                    w_c0[i]    = 1'b1;
                end
                OP_DEC: begin
                    w_b_eff[i] = '1;
                    w_c0[i]    = 1'b0;
                end
                OP_NEG: begin
                    // 0 + ~a + 1 gives the two's-complement negation of a
                    w_a_eff[i] = '0;
                    w_b_eff[i] = ~a[i*LW +: LW];
                    w_c0[i]    = 1'b1;
                end
                OP_CMP: begin
                    w_b_eff[i] = ~b[i*LW +: LW];
                    w_c0[i]    = 1'b1;
                end
            endcase
            w_sum[i]  = {1'b0, w_a_eff[i]} + {1'b0, w_b_eff[i]} + {{LW{1'b0}}, w_c0[i]};
            w_amsb[i] = w_a_eff[i][LW-1];
            w_bmsb[i] = w_b_eff[i][LW-1];
        end
    end

    // ---- Stage 1: sum, operand MSBs, result and op decode -------------------
    // The data registers advance every cycle; only r_vld_p1 says whether the
    // captured contents belong to a real operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_sum_p1   <= '0;
            r_amsb_p1  <= '0;
            r_bmsb_p1  <= '0;
            r_res_p1   <= '0;
            r_logic_p1 <= 1'b0;
            r_cmp_p1   <= 1'b0;
        end else begin
            r_vld_p1   <= in_valid;
            r_sum_p1   <= w_sum;
            r_amsb_p1  <= w_amsb;
            r_bmsb_p1  <= w_bmsb;
            r_res_p1   <= result;
            r_logic_p1 <= mode;
            // CMP only changes Z/S sourcing in arithmetic mode
            r_cmp_p1   <= ~mode & (opsel == OP_CMP);
        end
    end

    // Flag derivation. CMP takes Z/S from the internal difference because the
    // datapath does not write a result for it.
    always_comb begin
        w_c_new = '0;
        w_z_new = '0;
        w_s_new = '0;
        w_o_new = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_cmp_p1) begin
                w_z_new[i] = (r_sum_p1[i][LW-1:0] == '0);
                w_s_new[i] = r_sum_p1[i][LW-1];
            end else begin
                w_z_new[i] = (r_res_p1[i*LW +: LW] == '0);
                w_s_new[i] = r_res_p1[i*LW + LW - 1];
            end
            w_c_new[i] = ~r_logic_p1 & r_sum_p1[i][LW];
            w_o_new[i] = ~r_logic_p1 & (r_amsb_p1[i] == r_bmsb_p1[i])
                                     & (r_sum_p1[i][LW-1] != r_amsb_p1[i]);
        end
    end

    // ---- Stage 2: registered flags ------------------------------------------
    // The flags hold their last value whenever no operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2 <= 1'b0;
            r_c_p2   <= '0;
            r_z_p2   <= '0;
            r_s_p2   <= '0;
            r_o_p2   <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_c_p2 <= w_c_new;
                r_z_p2 <= w_z_new;
                r_s_p2 <= w_s_new;
                r_o_p2 <= w_o_new;
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign c_flag    = r_c_p2;
    assign z_flag    = r_z_p2;
    assign s_flag    = r_s_p2;
    assign o_flag    = r_o_p2;

    // Sticky status updates on the same edge as the flags, so a clear and a
    // completing operation in the same cycle leave the new flag bits set.
    generate
        if (STICKY_EN) begin : g_sticky
            logic [LANES-1:0] r_sticky_c_p2;
            logic [LANES-1:0] r_sticky_o_p2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sticky_c_p2 <= '0;
                    r_sticky_o_p2 <= '0;
                end else if (r_vld_p1) begin
                    r_sticky_c_p2 <= (sticky_clr ? '0 : r_sticky_c_p2) | w_c_new;
                    r_sticky_o_p2 <= (sticky_clr ? '0 : r_sticky_o_p2) | w_o_new;
                end else if (sticky_clr) begin
                    r_sticky_c_p2 <= '0;
                    r_sticky_o_p2 <= '0;
                end
            end

            assign sticky_c = r_sticky_c_p2;
            assign sticky_o = r_sticky_o_p2;
        end else begin : g_no_sticky
            assign sticky_c = '0;
            assign sticky_o = '0;
        end
    endgenerate

endmodule

// File: tb/tb_alu_flag_unit.sv
module tb_alu_flag_unit;

    localparam int W = 128;

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [2:0]     opsel;
    logic           mode;
    logic           cin;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   result;
    logic           sticky_clr;

    logic           ov1, c1, z1, s1, o1, sc1, so1;
    logic           ov4;
    logic [3:0]     c4, z4, s4, o4, sc4, so4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_flag_unit #(.WIDTH(W), .LANES(1), .STICKY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opsel(opsel), .mode(mode),
        .cin(cin), .a(a), .b(b), .result(result), .sticky_clr(sticky_clr),
        .out_valid(ov1), .c_flag(c1), .z_flag(z1), .s_flag(s1), .o_flag(o1),
        .sticky_c(sc1), .sticky_o(so1)
    );

    alu_flag_unit #(.WIDTH(W), .LANES(4), .STICKY_EN(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opsel(opsel), .mode(mode),
        .cin(cin), .a(a), .b(b), .result(result), .sticky_clr(sticky_clr),
        .out_valid(ov4), .c_flag(c4), .z_flag(z4), .s_flag(s4), .o_flag(o4),
        .sticky_c(sc4), .sticky_o(so4)
    );

    typedef struct {
        logic [2:0]   op;
        logic         md;
        logic         ci;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] vr;
        logic [3:0]   czso;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic md, input logic ci,
                         input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vr);
        opsel    = op;
        mode     = md;
        cin      = ci;
        a        = va;
        b        = vb;
        result   = vr;
        in_valid = 1'b1;
    endtask

    // Issue one op, check it is not visible after one edge, optionally hold
    // sticky_clr for the edge on which the flags land, and stop there.
    task automatic run_op(input string name, input logic [2:0] op, input logic md, input logic ci,
                          input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vr,
                          input logic clr_at_out);
        drive(op, md, ci, va, vb, vr);
        step();
        in_valid = 1'b0;
        check({name, "_lat1"}, 32'(ov1), 32'd0);
        sticky_clr = clr_at_out;
        step();
        sticky_clr = 1'b0;
        check({name, "_valid"}, 32'(ov1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {C,Z,S,O}
        vt[0]  = '{3'b000, 1'b0, 1'b0, ONES, ONE, '0, 4'b1100};            // ADD wrap to 0
        vt[1]  = '{3'b000, 1'b0, 1'b0, MAXP, ONE, MINN, 4'b0011};          // ADD overflow
        vt[2]  = '{3'b111, 1'b0, 1'b0, W'(5), W'(5), W'(16'hDEAD), 4'b1100}; // CMP equal
        vt[3]  = '{3'b010, 1'b0, 1'b0, W'(3), W'(5), ONES - ONE, 4'b0010}; // SUB borrow
        vt[4]  = '{3'b010, 1'b1, 1'b0, ONES, ONES, '0, 4'b0100};           // logic, result 0
        vt[5]  = '{3'b001, 1'b0, 1'b1, ONES, '0, '0, 4'b1100};             // ADC with cin
        vt[6]  = '{3'b011, 1'b0, 1'b0, W'(5), W'(5), ONES, 4'b0010};       // SBB cin=0 borrow
        vt[7]  = '{3'b100, 1'b0, 1'b0, MAXP, '0, MINN, 4'b0011};           // INC overflow
        vt[8]  = '{3'b101, 1'b0, 1'b0, '0, '0, ONES, 4'b0010};             // DEC 0 -> borrow
        vt[9]  = '{3'b101, 1'b0, 1'b0, MINN, '0, MAXP, 4'b1001};           // DEC overflow
        vt[10] = '{3'b110, 1'b0, 1'b0, MINN, '0, MINN, 4'b0011};           // NEG of min
        vt[11] = '{3'b110, 1'b0, 1'b0, '0, '0, '0, 4'b1100};               // NEG of 0
        vt[12] = '{3'b111, 1'b0, 1'b0, W'(3), W'(5), '0, 4'b0010};         // CMP less, result ignored
        vt[13] = '{3'b111, 1'b1, 1'b0, ONES, ONE, MINN, 4'b0010};          // logic, negative result
        vt[14] = '{3'b000, 1'b0, 1'b0, MINN, MINN, '0, 4'b1101};           // ADD neg overflow
        vt[15] = '{3'b001, 1'b0, 1'b0, ONE, ONE, W'(2), 4'b0000};          // ADC cin=0
        vt[16] = '{3'b001, 1'b0, 1'b1, MAXP, '0, MINN, 4'b0011};           // ADC cin=1 overflow
        vt[17] = '{3'b011, 1'b0, 1'b1, W'(5), W'(5), '0, 4'b1100};         // SBB cin=1

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        opsel      = '0;
        mode       = 1'b0;
        cin        = 1'b0;
        a          = '0;
        b          = '0;
        result     = '0;
        sticky_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_l1", 32'({ov1, c1, z1, s1, o1, sc1, so1}), 32'd0);
        check("reset_l4", 32'({ov4, c4, z4, s4, o4, sc4, so4}), 32'd0);
        rst_n = 1'b1;
        step();

        // Table of single operations on the one-lane instance
        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].md, vt[i].ci,
                   vt[i].va, vt[i].vb, vt[i].vr, 1'b0);
            check($sformatf("vec%0d_czso", i), 32'({c1, z1, s1, o1}), 32'(vt[i].czso));
            step();
            check($sformatf("vec%0d_vld_drop", i), 32'(ov1), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'({c1, z1, s1, o1}), 32'(vt[i].czso));
        end

        // Sticky overflow persists until cleared
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_clr_idle", 32'({sc1, so1}), 32'd0);
        run_op("st_ovf", 3'b000, 1'b0, 1'b0, MAXP, ONE, MINN, 1'b0);
        check("st_ovf_o", 32'({o1, sc1, so1}), 32'b101);
        run_op("st_keep", 3'b000, 1'b0, 1'b0, ONE, ONE, W'(2), 1'b0);
        check("st_keep_o", 32'({o1, sc1, so1}), 32'b001);
        step();
        check("st_idle_hold", 32'({sc1, so1}), 32'b01);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("st_clear", 32'({sc1, so1}), 32'd0);

        // Four lanes: carries must not cross lane boundaries
        run_op("lanes4", 3'b000, 1'b0, 1'b0,
               {32'h0, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF},
               {32'h0, 32'h8000_0000, 32'h1, 32'h1},
               {32'h0, 32'h0, 32'h2, 32'h0}, 1'b0);
        check("lanes4_valid", 32'(ov4), 32'd1);
        check("lanes4_c", 32'(c4), 32'b0101);
        check("lanes4_o", 32'(o4), 32'b0100);
        check("lanes4_z", 32'(z4), 32'b1101);
        check("lanes4_s", 32'(s4), 32'b0000);

        // Eight back-to-back logic ops: flags come out in issue order
        for (int j = 0; j < 10; j++) begin
            logic [2:0] k;
            k = 3'(j);
            if (j < 8) begin
                drive(3'b010, 1'b1, 1'b0, ONES, ONES, {k[0] ^ k[1], {(W-2){1'b0}}, k[2]});
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (j == 0) begin
                check("b2b_pre", 32'(ov1), 32'd0);
            end else if (j <= 8) begin
                logic [2:0] p;
                logic       exp_s;
                logic       exp_z;
                p     = 3'(j - 1);
                exp_s = p[0] ^ p[1];
                exp_z = ~exp_s & ~p[2];
                check($sformatf("b2b%0d", j - 1), 32'({ov1, c1, z1, s1, o1}),
                      32'({1'b1, 1'b0, exp_z, exp_s, 1'b0}));
            end else begin
                check("b2b_post", 32'(ov1), 32'd0);
            end
        end

        // Sticky clear and new bits on the same edge: new bits survive
        run_op("cs_carry", 3'b000, 1'b0, 1'b0, ONES, ONE, '0, 1'b0);
        check("cs_carry_st", 32'({sc1, so1}), 32'b10);
        run_op("cs_both", 3'b000, 1'b0, 1'b0, MAXP, ONE, MINN, 1'b1);
        check("cs_both_st", 32'({sc1, so1}), 32'b01);

        // Asynchronous reset with operations in flight
        drive(3'b000, 1'b0, 1'b0, ONES, ONE, '0);
        step();
        drive(3'b000, 1'b0, 1'b0, MAXP, ONE, MINN);
        step();
        drive(3'b000, 1'b0, 1'b0, MINN, MINN, '0);
        check("pre_rst_flags", 32'({ov1, c1, z1}), 32'b111);
        rst_n = 1'b0;
        #1;
        check("midrst_l1", 32'({ov1, c1, z1, s1, o1, sc1, so1}), 32'd0);
        check("midrst_l4", 32'({ov4, c4, z4, s4, o4, sc4, so4}), 32'd0);
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            check($sformatf("post_rst_vld%0d", j), 32'({ov1, ov4}), 32'd0);
        end
        check("post_rst_flags", 32'({c1, z1, s1, o1, sc1, so1}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
